// File: rtl/rx_chain_pkg.sv
// Shared constants, sample/result typedefs and flattened-vector helpers for the RX chain model.
package rx_chain_pkg;

  localparam int RATE_MIN  = 4;
  localparam int VEC_MAX_W = 1024;
  localparam int DEF_IQ_W  = 16;
  localparam int DEF_ACC_W = 32;

  typedef struct packed {
    logic signed [DEF_IQ_W-1:0] q;
    logic signed [DEF_IQ_W-1:0] i;
  } iq_sample_t;

  typedef struct packed {
    logic signed [DEF_ACC_W-1:0] q_sum;
    logic signed [DEF_ACC_W-1:0] i_sum;
  } iq_sum_t;

  // Extracts bits [c*w +: w] of a flattened vector; w must not exceed 64.
  function automatic logic [63:0] chan_bits(input logic [VEC_MAX_W-1:0] vec,
                                            input int c, input int w);
    logic [63:0] mask;
    mask = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return 64'(vec >> (c * w)) & mask;
  endfunction

endpackage

// File: rtl/rx_chain_fifo.sv
// Synchronous FIFO with a registered head word; dout never depends combinationally on pop.
module rx_chain_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_next;
  logic [AW:0]      count;
  logic             wr_en;
  logic             rd_en;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_en   = pop && !empty;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign wr_en   = push && (!full || rd_en);
  assign rd_next = rd_ptr + AW'(rd_en);

  always_ff @(posedge clk) begin
    if (wr_en && !clr) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      rd_ptr <= rd_next;
      count  <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      // Next head is either the word being written into the head slot or the stored successor.
      if (wr_en && (wr_ptr == rd_next)) begin
        dout <= din;
      end else if (rd_en) begin
        dout <= mem[rd_next];
      end
    end
  end

endmodule

// File: rtl/rx_chain_multi_model.sv
// Multi-channel RX chain: per-channel decimating I/Q summer feeding an AXI-stream FIFO.
// Defining RX_CHAIN_MULTI_OVF_CNT_EN adds overflow_cnt_o, a saturating per-channel drop count.
module rx_chain_multi_model
  import rx_chain_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int IQ_W       = 16,
  parameter int ACC_W      = 32,
  parameter int RATE_W     = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH-1:0]        en_i,
  input  logic [N_CH*RATE_W-1:0] rate_axis_tdata_i,
  input  logic [N_CH-1:0]        rate_axis_tvalid_i,
  input  logic [N_CH*2*IQ_W-1:0] rx_iq_axis_tdata_i,
  input  logic [N_CH-1:0]        rx_iq_axis_tvalid_i,
  input  logic [N_CH-1:0]        axis_tready_i,
  output logic [N_CH*2*ACC_W-1:0] axis_tdata_o,
  output logic [N_CH-1:0]        axis_tvalid_o,
  output logic [N_CH-1:0]        overflow_o
`ifdef RX_CHAIN_MULTI_OVF_CNT_EN
  ,
  output logic [N_CH*16-1:0]     overflow_cnt_o
`endif
);

  // Output handshake: a word transfers on a rising clk edge where axis_tvalid_o[c] and
  // axis_tready_i[c] are both high; tvalid is registered and never depends on tready.

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [RATE_W-1:0]       rate_in;
    logic [RATE_W-1:0]       rate_q;
    logic [RATE_W-1:0]       cnt;
    logic [2*IQ_W-1:0]       sample;
    logic signed [ACC_W-1:0] ext_i;
    logic signed [ACC_W-1:0] ext_q;
    logic signed [ACC_W-1:0] acc_i;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] sum_i;
    logic signed [ACC_W-1:0] sum_q;
    logic                    en;
    logic                    rate_vld;
    logic                    smp_vld;
    logic                    last;
    logic                    push;
    logic                    pop;
    logic                    full;
    logic                    empty;
    logic                    drop;
    logic                    ovf;
    logic [2*ACC_W-1:0]      push_data;
    logic [2*ACC_W-1:0]      head;

    assign en       = en_i[c];
    assign rate_vld = rate_axis_tvalid_i[c];
    assign smp_vld  = rx_iq_axis_tvalid_i[c];
    assign rate_in  = RATE_W'(chan_bits(VEC_MAX_W'(rate_axis_tdata_i), c, RATE_W));
    assign sample   = (2*IQ_W)'(chan_bits(VEC_MAX_W'(rx_iq_axis_tdata_i), c, 2*IQ_W));

    assign ext_i = {{(ACC_W-IQ_W){sample[IQ_W-1]}}, sample[IQ_W-1:0]};
    assign ext_q = {{(ACC_W-IQ_W){sample[2*IQ_W-1]}}, sample[2*IQ_W-1:IQ_W]};
    assign sum_i = acc_i + ext_i;
    assign sum_q = acc_q + ext_q;
    assign last  = (cnt == rate_q - RATE_W'(1));

    assign pop  = !empty && axis_tready_i[c];
    assign drop = push && full && !pop;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rate_q    <= RATE_W'(RATE_MIN);
        cnt       <= '0;
        acc_i     <= '0;
        acc_q     <= '0;
        push      <= 1'b0;
        push_data <= '0;
        ovf       <= 1'b0;
      end else begin
        if (rate_vld) begin
          rate_q <= (rate_in < RATE_W'(RATE_MIN)) ? RATE_W'(RATE_MIN) : rate_in;
        end
        push <= 1'b0;
        if (!en) begin
          cnt   <= '0;
          acc_i <= '0;
          acc_q <= '0;
          ovf   <= 1'b0;
        end else begin
          // A rate load restarts the group; a coincident sample becomes its first member.
          if (rate_vld) begin
            if (smp_vld) begin
              cnt   <= RATE_W'(1);
              acc_i <= ext_i;
              acc_q <= ext_q;
            end else begin
              cnt   <= '0;
              acc_i <= '0;
              acc_q <= '0;
            end
          end else if (smp_vld) begin
            if (last) begin
              push      <= 1'b1;
              push_data <= {sum_q, sum_i};
              cnt       <= '0;
              acc_i     <= '0;
              acc_q     <= '0;
            end else begin
              cnt   <= cnt + RATE_W'(1);
              acc_i <= sum_i;
              acc_q <= sum_q;
            end
          end
          if (drop) begin
            ovf <= 1'b1;
          end
        end
      end
    end

    rx_chain_fifo #(
      .WIDTH (2*ACC_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (!en),
      .push  (push),
      .din   (push_data),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
    );

    assign axis_tdata_o[c*2*ACC_W +: 2*ACC_W] = head;
    assign axis_tvalid_o[c]                   = !empty;
    assign overflow_o[c]                      = ovf;

`ifdef RX_CHAIN_MULTI_OVF_CNT_EN
    logic [15:0] ovf_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ovf_cnt <= '0;
      end else if (!en) begin
        ovf_cnt <= '0;
      end else if (drop && (ovf_cnt != 16'hFFFF)) begin
        ovf_cnt <= ovf_cnt + 16'd1;
      end
    end

    assign overflow_cnt_o[c*16 +: 16] = ovf_cnt;
`endif
  end

endmodule

// File: tb/tb_rx_chain_multi_model.sv
// Directed bench for rx_chain_multi_model: hand-computed group sums checked through a scoreboard.
module tb_rx_chain_multi_model;
  import rx_chain_pkg::*;

  localparam int N_CH       = 2;
  localparam int IQ_W       = 16;
  localparam int ACC_W      = 32;
  localparam int RATE_W     = 16;
  localparam int FIFO_DEPTH = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [N_CH-1:0]          en = '0;
  logic [N_CH*RATE_W-1:0]   rate_data = '0;
  logic [N_CH-1:0]          rate_vld = '0;
  logic [N_CH*2*IQ_W-1:0]   smp_data = '0;
  logic [N_CH-1:0]          smp_vld = '0;
  logic [N_CH-1:0]          tready = '0;
  logic [N_CH*2*ACC_W-1:0]  tdata;
  logic [N_CH-1:0]          tvalid;
  logic [N_CH-1:0]          ovf;
`ifdef RX_CHAIN_MULTI_OVF_CNT_EN
  logic [N_CH*16-1:0]       ovf_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int pops0 = 0;
  int pops1 = 0;
  logic [2*ACC_W-1:0] exp_q0[$];
  logic [2*ACC_W-1:0] exp_q1[$];

  rx_chain_multi_model #(
    .N_CH (N_CH), .IQ_W (IQ_W), .ACC_W (ACC_W), .RATE_W (RATE_W), .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .en_i                (en),
    .rate_axis_tdata_i   (rate_data),
    .rate_axis_tvalid_i  (rate_vld),
    .rx_iq_axis_tdata_i  (smp_data),
    .rx_iq_axis_tvalid_i (smp_vld),
    .axis_tready_i       (tready),
    .axis_tdata_o        (tdata),
    .axis_tvalid_o       (tvalid),
    .overflow_o          (ovf)
`ifdef RX_CHAIN_MULTI_OVF_CNT_EN
    ,
    .overflow_cnt_o      (ovf_cnt)
`endif
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int i, input int q);
    iq_sum_t w;
    w.i_sum = i;
    w.q_sum = q;
    return w;
  endfunction

  // Scoreboard: every accepted output word must match the head of its channel's queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (tvalid[0] && tready[0]) begin
        pops0++;
        if (exp_q0.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL ch0_unexpected_word observed=%0h expected=none", tdata[63:0]);
        end else begin
          check64("ch0_word", tdata[63:0], exp_q0.pop_front());
        end
      end
      if (tvalid[1] && tready[1]) begin
        pops1++;
        if (exp_q1.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL ch1_unexpected_word observed=%0h expected=none", tdata[127:64]);
        end else begin
          check64("ch1_word", tdata[127:64], exp_q1.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic cycle(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_smp(input int ch, input logic v, input int i, input int q);
    iq_sample_t s;
    s.i = i[15:0];
    s.q = q[15:0];
    smp_vld[ch] = v;
    smp_data[ch*32 +: 32] = s;
  endtask

  task automatic feed(input int ch, input int n, input int i, input int q);
    set_smp(ch, 1'b1, i, q);
    cycle(n);
    set_smp(ch, 1'b0, 0, 0);
  endtask

  task automatic load_rate(input int ch, input int r);
    rate_data[ch*16 +: 16] = r[15:0];
    rate_vld[ch] = 1'b1;
    cycle();
    rate_vld[ch] = 1'b0;
  endtask

  task automatic wait_drain(input int ch, input int bound);
    int left;
    for (int k = 0; k < bound; k++) begin
      left = (ch == 0) ? exp_q0.size() : exp_q1.size();
      if (left == 0) break;
      cycle();
    end
    left = (ch == 0) ? exp_q0.size() : exp_q1.size();
    check64($sformatf("drain_ch%0d", ch), 64'(left), 64'd0);
  endtask

  initial begin
    int p0;
    int p1;

    // Reset state
    #1 rst = 1'b1;
    cycle(2);
    check64("rst_tvalid", 64'(tvalid), 64'd0);
    check64("rst_tdata", tdata[63:0], 64'd0);
    check64("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b0;
    en = 2'b11;
    tready = 2'b11;
    cycle();

    // Rate 4 streaming: one word per 4 samples, tvalid one cycle after the 4th sample
    for (int k = 0; k < 3; k++) exp_q0.push_back(mk(400, -200));
    set_smp(0, 1'b1, 100, -50);
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (k == 4) check64("lat_before", 64'(tvalid[0]), 64'd0);
      if (k == 5) check64("lat_after", 64'(tvalid[0]), 64'd1);
    end
    set_smp(0, 1'b0, 0, 0);
    wait_drain(0, 20);
    check64("stream_pops", 64'(pops0), 64'd3);

    // Rate 2 clamps to 4
    load_rate(0, 2);
    feed(0, 3, 5, -7);
    cycle(4);
    check64("clamp_no_early", 64'(tvalid[0]), 64'd0);
    exp_q0.push_back(mk(20, -28));
    feed(0, 1, 5, -7);
    wait_drain(0, 10);

    // Backpressure: 20 groups into a 16-deep FIFO, 4 dropped
    tready[0] = 1'b0;
    for (int g = 0; g < 20; g++) begin
      set_smp(0, 1'b1, 100 + g, -50);
      cycle(4);
    end
    set_smp(0, 1'b0, 0, 0);
    cycle(3);
    check64("bp_tvalid", 64'(tvalid[0]), 64'd1);
    check64("bp_ovf0", 64'(ovf[0]), 64'd1);
    check64("bp_ovf1", 64'(ovf[1]), 64'd0);
`ifdef RX_CHAIN_MULTI_OVF_CNT_EN
    check64("bp_ovf_cnt", 64'(ovf_cnt[15:0]), 64'd4);
`endif
    for (int g = 0; g < 16; g++) exp_q0.push_back(mk(400 + 4 * g, -200));
    p0 = pops0;
    tready[0] = 1'b1;
    wait_drain(0, 40);
    cycle(3);
    check64("bp_drain_count", 64'(pops0 - p0), 64'd16);
    check64("bp_empty", 64'(tvalid[0]), 64'd0);
    check64("bp_ovf_sticky", 64'(ovf[0]), 64'd1);
    en[0] = 1'b0;
    cycle();
    check64("ovf_clr_en", 64'(ovf[0]), 64'd0);
    en[0] = 1'b1;
    cycle();

    // Rate reload discards the partial group
    load_rate(0, 4);
    feed(0, 2, 1000, 1000);
    load_rate(0, 4);
    exp_q0.push_back(mk(4, -4));
    feed(0, 4, 1, -1);
    wait_drain(0, 10);

    // Reload coinciding with a sample: that sample starts the new group
    exp_q0.push_back(mk(10, 10));
    feed(0, 2, 1000, 1000);
    rate_data[15:0] = 16'd4;
    rate_vld[0] = 1'b1;
    set_smp(0, 1'b1, 7, 7);
    cycle();
    rate_vld[0] = 1'b0;
    feed(0, 3, 1, 1);
    wait_drain(0, 10);

    // Two channels, rates 4 and 5, backpressure on channel 1 only
    load_rate(1, 5);
    tready[1] = 1'b0;
    for (int k = 0; k < 5; k++) exp_q0.push_back(mk(40, 80));
    for (int k = 0; k < 4; k++) exp_q1.push_back(mk(-15, 35));
    p0 = pops0;
    set_smp(0, 1'b1, 10, 20);
    set_smp(1, 1'b1, -3, 7);
    cycle(20);
    set_smp(0, 1'b0, 0, 0);
    set_smp(1, 1'b0, 0, 0);
    wait_drain(0, 30);
    check64("ch0_indep_pops", 64'(pops0 - p0), 64'd5);
    check64("ch1_held", 64'(tvalid[1]), 64'd1);
    check64("ch1_no_ovf", 64'(ovf[1]), 64'd0);
    p1 = pops1;
    tready[1] = 1'b1;
    wait_drain(1, 30);
    check64("ch1_pops", 64'(pops1 - p1), 64'd4);

    // Reset mid-group with 3 words buffered
    tready[0] = 1'b0;
    feed(0, 14, 3, 4);
    cycle(2);
    check64("pre_rst_tvalid", 64'(tvalid[0]), 64'd1);
    rst = 1'b1;
    #1;
    check64("midrst_tvalid", 64'(tvalid[0]), 64'd0);
    check64("midrst_tdata", tdata[63:0], 64'd0);
    check64("midrst_ovf", 64'(ovf), 64'd0);
    cycle(2);
    rst = 1'b0;
    tready[0] = 1'b1;
    feed(0, 3, 2, 2);
    cycle(4);
    check64("post_rst_partial", 64'(tvalid[0]), 64'd0);
    exp_q0.push_back(mk(8, 8));
    feed(0, 1, 2, 2);
    wait_drain(0, 10);
    cycle(3);
    check64("final_q1_empty", 64'(exp_q1.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
